// File: rtl/ibex_prefetch_buffer_mo_pkg.sv
// Shared types and sizing helpers for the multi-outstanding prefetch buffer.
// pf_entry_t is the default buffered-word layout for the standard 32-bit PC.
package ibex_prefetch_buffer_mo_pkg;

    localparam int unsigned PfAddrWidth      = 32;
    localparam int unsigned PfMaxOutstanding = 2;
    localparam int unsigned PfCntWidth       = $clog2(PfMaxOutstanding + 1);

    typedef struct packed {
        logic [31:0]            rdata;
        logic [PfAddrWidth-1:0] addr;
        logic                   err;
    } pf_entry_t;

    // Width of a counter that must reach n inclusive.
    function automatic int unsigned pf_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ibex_prefetch_fifo_n.sv
// Synchronous, non-fall-through FIFO of fetched words with a flush input.
// Push and pop may coincide when full; the caller guarantees no overflow.
module ibex_prefetch_fifo_n
    import ibex_prefetch_buffer_mo_pkg::*;
#(
    parameter int unsigned Depth    = 3,
    parameter type         entry_t  = pf_entry_t,
    localparam int unsigned CntWidth = pf_cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                push_i,
    input  entry_t              wdata_i,
    input  logic                pop_i,
    output entry_t              rdata_o,
    output logic [CntWidth-1:0] count_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    entry_t                mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CntWidth-1:0]   count_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntWidth'(1);
                2'b01:   count_q <= count_q - CntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ibex_prefetch_buffer_mo.sv
// Instruction prefetch buffer with several fetches in flight, stale-response
// discard after a branch, and fetch halt after a bus error.
module ibex_prefetch_buffer_mo
    import ibex_prefetch_buffer_mo_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned FifoDepth      = 3,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 branch_i,
    input  logic [AddrWidth-1:0] branch_addr_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [31:0]          rdata_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 err_o,
    output logic                 instr_req_o,
    input  logic                 instr_gnt_i,
    output logic [AddrWidth-1:0] instr_addr_o,
    input  logic [31:0]          instr_rdata_i,
    input  logic                 instr_rvalid_i,
    input  logic                 instr_err_i,
    output logic                 busy_o
);

    localparam int unsigned CntWidth  = pf_cnt_width(MaxOutstanding);
    localparam int unsigned FCntWidth = pf_cnt_width(FifoDepth);
    localparam int unsigned QPtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef struct packed {
        logic [31:0]          rdata;
        logic [AddrWidth-1:0] addr;
        logic                 err;
    } entry_t;

    logic [AddrWidth-1:0] fetch_addr_q;
    logic [AddrWidth-1:0] branch_target;
    logic [CntWidth-1:0]  outst_q;
    logic [CntWidth-1:0]  discard_q;
    logic                 hold_q;
    logic                 halt_q;
    logic [AddrWidth-1:0] aq_mem_q [MaxOutstanding];
    logic [QPtrWidth-1:0] aq_wr_q;
    logic [QPtrWidth-1:0] aq_rd_q;
    logic [FCntWidth-1:0] fifo_count;
    entry_t               fifo_head;
    entry_t               fifo_wdata;
    logic [7:0]           inflight;
    logic                 slot_free, has_credit, req_start;
    logic                 grant, rvalid_ok, push, pop;

    function automatic logic [QPtrWidth-1:0] aq_inc(input logic [QPtrWidth-1:0] p);
        return (p == QPtrWidth'(MaxOutstanding - 1)) ? '0 : p + QPtrWidth'(1);
    endfunction

    assign branch_target = branch_addr_i & ~AddrWidth'(3);

    // Words already buffered plus words still owed by memory must fit in the FIFO.
    // A branch discards both, so the whole FIFO is available that cycle.
    assign inflight   = 8'(fifo_count) + 8'(outst_q) - 8'(discard_q);
    assign slot_free  = outst_q < CntWidth'(MaxOutstanding);
    assign has_credit = branch_i || (inflight < 8'(FifoDepth));
    assign req_start  = req_i && slot_free && has_credit && (branch_i || !halt_q);

    assign instr_req_o  = !rst_i && (hold_q || req_start);
    assign instr_addr_o = branch_i ? branch_target : fetch_addr_q;

    assign grant     = instr_req_o && instr_gnt_i;
    assign rvalid_ok = instr_rvalid_i && (outst_q != '0);
    assign push      = rvalid_ok && !branch_i && (discard_q == '0);
    assign pop       = valid_o && ready_i && !branch_i;

    assign fifo_wdata = '{rdata: instr_rdata_i, addr: aq_mem_q[aq_rd_q], err: instr_err_i};

    always_ff @(posedge clk_i) begin
        if (grant) aq_mem_q[aq_wr_q] <= instr_addr_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr_q <= '0;
            outst_q      <= '0;
            discard_q    <= '0;
            hold_q       <= 1'b0;
            halt_q       <= 1'b0;
            aq_wr_q      <= '0;
            aq_rd_q      <= '0;
        end else begin
            hold_q <= instr_req_o && !instr_gnt_i;

            if (grant)         fetch_addr_q <= instr_addr_o + AddrWidth'(4);
            else if (branch_i) fetch_addr_q <= branch_target;

            case ({grant, rvalid_ok})
                2'b10:   outst_q <= outst_q + CntWidth'(1);
                2'b01:   outst_q <= outst_q - CntWidth'(1);
                default: outst_q <= outst_q;
            endcase

            // Every old-target response still owed becomes stale on a branch.
            if (branch_i)                           discard_q <= outst_q - CntWidth'(rvalid_ok);
            else if (rvalid_ok && discard_q != '0)  discard_q <= discard_q - CntWidth'(1);

            if (branch_i)                  halt_q <= 1'b0;
            else if (push && instr_err_i)  halt_q <= 1'b1;

            // Stale responses also retire their address-queue slot.
            if (grant)     aq_wr_q <= aq_inc(aq_wr_q);
            if (rvalid_ok) aq_rd_q <= aq_inc(aq_rd_q);
        end
    end

    ibex_prefetch_fifo_n #(
        .Depth   (FifoDepth),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (branch_i),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign valid_o = (fifo_count != '0);
    assign rdata_o = valid_o ? fifo_head.rdata : '0;
    assign addr_o  = valid_o ? fifo_head.addr  : '0;
    assign err_o   = valid_o && fifo_head.err;
    assign busy_o  = (outst_q != '0) || instr_req_o;

    rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_ibex_prefetch_buffer_mo.sv
// Directed bench: a simple memory model answers grants, a scoreboard checks
// every word the consumer accepts against the expected fetch stream.
module tb_ibex_prefetch_buffer_mo;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_rvalid_i = 1'b0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    ibex_prefetch_buffer_mo #(
        .AddrWidth(32), .FifoDepth(3), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o),
        .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
        .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; logic err; } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          gnt_count = 0;
    logic        mem_gnt = 1'b1;
    logic        mem_hold = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic [31:0] mq[$];
    exp_t        exp_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] a, input logic e);
        exp_t x;
        x.addr = a;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Memory: grants per mem_gnt, answers in order one cycle after grant
    // unless mem_hold; forgets everything on reset.
    always @(posedge clk_i) begin
        if (rst_i) begin
            mq.delete();
        end else begin
            if (instr_rvalid_i && mq.size() > 0) void'(mq.pop_front());
            if (instr_req_o && instr_gnt_i) begin
                mq.push_back(instr_addr_o);
                gnt_count++;
            end
        end
        #2;
        instr_gnt_i = mem_gnt;
        if (!rst_i && !mem_hold && mq.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(mq[0]);
            instr_err_i    = (mq[0] == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
    end

    // Scoreboard: every accepted word must match the next expected one.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("word_addr", 64'(addr_o), 64'(e.addr));
                chk("word_rdata", 64'(rdata_o), 64'(mem_data(e.addr)));
                chk("word_err", 64'(err_o), 64'(e.err));
            end
        end
    end

    int g0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_req", 64'(instr_req_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_addr", 64'(addr_o), 0);
        chk("rst_rdata", 64'(rdata_o), 0);
        chk("rst_err", 64'(err_o), 0);
        cyc(); rst_i = 1'b0;

        // Back-to-back fetch from a zero-latency memory
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h100; req_i = 1'b1; ready_i = 1'b1;
        expect_word(32'h100, 1'b0); expect_word(32'h104, 1'b0); expect_word(32'h108, 1'b0);
        @(negedge clk_i);
        chk("s1_req0", 64'(instr_req_o), 1);
        chk("s1_iaddr0", 64'(instr_addr_o), 64'h100);
        chk("s1_valid0", 64'(valid_o), 0);
        cyc(); branch_i = 1'b0;
        @(negedge clk_i);
        chk("s1_iaddr1", 64'(instr_addr_o), 64'h104);
        chk("s1_valid1", 64'(valid_o), 0);
        cyc();
        @(negedge clk_i);
        chk("s1_valid2", 64'(valid_o), 1);
        chk("s1_addr2", 64'(addr_o), 64'h100);
        chk("s1_iaddr2", 64'(instr_addr_o), 64'h108);
        cyc(); req_i = 1'b0;
        repeat (4) cyc();
        @(negedge clk_i);
        chk("s1_drained", 64'(exp_q.size()), 0);
        chk("s1_idle_valid", 64'(valid_o), 0);
        chk("s1_idle_busy", 64'(busy_o), 0);

        // Consumer stalled: credit stops at FifoDepth words
        g0 = gnt_count;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h1000; req_i = 1'b1; ready_i = 1'b0;
        cyc(); branch_i = 1'b0;
        repeat (8) cyc();
        @(negedge clk_i);
        chk("s2_grants3", 64'(gnt_count - g0), 3);
        chk("s2_req_off", 64'(instr_req_o), 0);
        chk("s2_full_valid", 64'(valid_o), 1);
        chk("s2_head", 64'(addr_o), 64'h1000);
        expect_word(32'h1000, 1'b0);
        cyc(); ready_i = 1'b1;
        cyc(); ready_i = 1'b0;
        repeat (6) cyc();
        @(negedge clk_i);
        chk("s2_grants4", 64'(gnt_count - g0), 4);
        chk("s2_head2", 64'(addr_o), 64'h1004);
        chk("s2_drained", 64'(exp_q.size()), 0);

        // Branch with two responses outstanding: both become stale
        mem_hold = 1'b1;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h200;
        @(negedge clk_i);
        chk("s3_iaddr0", 64'(instr_addr_o), 64'h200);
        cyc(); branch_i = 1'b0;
        @(negedge clk_i);
        chk("s3_iaddr1", 64'(instr_addr_o), 64'h204);
        chk("s3_req1", 64'(instr_req_o), 1);
        cyc();
        @(negedge clk_i);
        chk("s3_req_full", 64'(instr_req_o), 0);
        chk("s3_busy", 64'(busy_o), 1);
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h402;
        @(negedge clk_i);
        chk("s3_br_iaddr", 64'(instr_addr_o), 64'h400);
        chk("s3_br_noreq", 64'(instr_req_o), 0);
        cyc(); branch_i = 1'b0; mem_hold = 1'b0;
        repeat (8) cyc();
        @(negedge clk_i);
        chk("s3_valid", 64'(valid_o), 1);
        chk("s3_head", 64'(addr_o), 64'h400);
        chk("s3_head_data", 64'(rdata_o), 64'(mem_data(32'h400)));
        chk("s3_discard", 64'(dut.discard_q), 0);

        // Grant withheld: request holds; branch may retarget it
        mem_gnt = 1'b0;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h300;
        @(negedge clk_i);
        chk("s4_req_c0", 64'(instr_req_o), 1);
        chk("s4_iaddr_c0", 64'(instr_addr_o), 64'h300);
        cyc(); branch_i = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk_i);
            chk("s4_req_hold", 64'(instr_req_o), 1);
            chk("s4_iaddr_hold", 64'(instr_addr_o), 64'h300);
            if (i < 2) cyc();
        end
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h500;
        @(negedge clk_i);
        chk("s4_br_iaddr", 64'(instr_addr_o), 64'h500);
        cyc(); branch_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("s4_req_hold2", 64'(instr_req_o), 1);
            chk("s4_iaddr_hold2", 64'(instr_addr_o), 64'h500);
            cyc();
        end
        mem_gnt = 1'b1;
        repeat (8) cyc();
        @(negedge clk_i);
        chk("s4_head", 64'(addr_o), 64'h500);

        // Bus error halts fetching until the next branch
        err_addr = 32'h604;
        g0 = gnt_count;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h600;
        expect_word(32'h600, 1'b0); expect_word(32'h604, 1'b1); expect_word(32'h608, 1'b0);
        cyc(); branch_i = 1'b0; ready_i = 1'b1;
        repeat (8) cyc();
        @(negedge clk_i);
        chk("s5_grants", 64'(gnt_count - g0), 3);
        chk("s5_halted", 64'(instr_req_o), 0);
        chk("s5_drained", 64'(exp_q.size()), 0);
        g0 = gnt_count;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h700;
        expect_word(32'h700, 1'b0);
        @(negedge clk_i);
        chk("s5_resume_req", 64'(instr_req_o), 1);
        cyc(); branch_i = 1'b0; req_i = 1'b0;
        repeat (6) cyc();
        @(negedge clk_i);
        chk("s5_resume_grants", 64'(gnt_count - g0), 1);
        chk("s5_resume_drained", 64'(exp_q.size()), 0);

        // Reset with two fetches in flight
        mem_hold = 1'b1;
        g0 = gnt_count;
        cyc(); branch_i = 1'b1; branch_addr_i = 32'h800; req_i = 1'b1; ready_i = 1'b0;
        cyc(); branch_i = 1'b0;
        cyc();
        @(negedge clk_i);
        chk("s6_busy", 64'(busy_o), 1);
        cyc(); rst_i = 1'b1;
        @(negedge clk_i);
        chk("s6_rst_valid", 64'(valid_o), 0);
        chk("s6_rst_req", 64'(instr_req_o), 0);
        chk("s6_rst_busy", 64'(busy_o), 0);
        chk("s6_rst_addr", 64'(addr_o), 0);
        cyc(); rst_i = 1'b0; req_i = 1'b0; mem_hold = 1'b0; ready_i = 1'b1;
        repeat (6) cyc();
        @(negedge clk_i);
        chk("s6_no_stale", 64'(valid_o), 0);
        chk("s6_idle", 64'(busy_o), 0);
        chk("s6_grants", 64'(gnt_count - g0), 2);
        chk("s6_drained", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
